// File: rtl/memshare_ib_remap_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// memshare_ib_remap_loader : streams a full IB-LUT image into the share-group
// IB-RAM rank remap port, one rank-wide word per address, then pulses done.
// Revision: 1.0
// ---------------------------------------------------------------------------
module memshare_ib_remap_loader #(
  parameter int MSG_WIDTH     = 4,
  parameter int GROUP_SIZE    = 4,
  parameter int COL_SEL_WIDTH = 1,
  parameter int ADDR_WIDTH    = COL_SEL_WIDTH + MSG_WIDTH,
  parameter int ENTRY_NUM     = 2 ** ADDR_WIDTH
) (
  input  logic                                sys_clk,
  input  logic                                rstn,
  input  logic                                load_req_i,
  input  logic                                load_abort_i,
  input  logic                                entry_valid_i,
  input  logic [MSG_WIDTH*GROUP_SIZE-1:0]     entry_data_i,
  output logic                                entry_ready_o,
  output logic [COL_SEL_WIDTH*GROUP_SIZE-1:0] remap_colSel_vec_o,
  output logic [MSG_WIDTH*GROUP_SIZE-1:0]     remap_c2v_vec_o,
  output logic [MSG_WIDTH*GROUP_SIZE-1:0]     remap_dataIn_vec_o,
  output logic                                nRemap_en_o,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                aborted_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                            state, state_nxt;
  logic [ADDR_WIDTH-1:0]             addr_cnt, addr_nxt;
  logic                              nremap, nremap_nxt;
  logic                              ready, ready_nxt;
  logic                              busy, busy_nxt;
  logic                              done, done_nxt;
  logic                              aborted, aborted_nxt;
  logic [COL_SEL_WIDTH*GROUP_SIZE-1:0] colsel, colsel_nxt;
  logic [MSG_WIDTH*GROUP_SIZE-1:0]   c2v, c2v_nxt;
  logic [MSG_WIDTH*GROUP_SIZE-1:0]   data, data_nxt;

  logic accept;
  logic last_addr;

  assign accept    = entry_valid_i & ready;
  assign last_addr = (addr_cnt == ADDR_WIDTH'(ENTRY_NUM - 1));

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      addr_cnt <= '0;
      nremap   <= 1'b1;
      ready    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      colsel   <= '0;
      c2v      <= '0;
      data     <= '0;
    end else begin
      state    <= state_nxt;
      addr_cnt <= addr_nxt;
      nremap   <= nremap_nxt;
      ready    <= ready_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      aborted  <= aborted_nxt;
      colsel   <= colsel_nxt;
      c2v      <= c2v_nxt;
      data     <= data_nxt;
    end
  end

  // The write enable defaults high each cycle so only an accept produces a write.
  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr_cnt;
    nremap_nxt  = 1'b1;
    ready_nxt   = ready;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    aborted_nxt = 1'b0;
    colsel_nxt  = colsel;
    c2v_nxt     = c2v;
    data_nxt    = data;

    case (state)
      IDLE: begin
        if (load_req_i) begin
          state_nxt = LOAD;
          addr_nxt  = '0;
          busy_nxt  = 1'b1;
          ready_nxt = 1'b1;
        end
      end

      LOAD: begin
        if (load_abort_i) begin
          state_nxt   = IDLE;
          addr_nxt    = '0;
          ready_nxt   = 1'b0;
          busy_nxt    = 1'b0;
          aborted_nxt = 1'b1;
        end else if (accept) begin
          nremap_nxt = 1'b0;
          colsel_nxt = {GROUP_SIZE{addr_cnt[ADDR_WIDTH-1:MSG_WIDTH]}};
          c2v_nxt    = {GROUP_SIZE{addr_cnt[MSG_WIDTH-1:0]}};
          data_nxt   = entry_data_i;
          addr_nxt   = addr_cnt + 1'b1;
          if (last_addr) begin
            state_nxt = FINISH;
            ready_nxt = 1'b0;
            addr_nxt  = '0;
          end
        end
      end

      FINISH: begin
        state_nxt = IDLE;
        ready_nxt = 1'b0;
        busy_nxt  = 1'b0;
        addr_nxt  = '0;
        if (load_abort_i) begin
          aborted_nxt = 1'b1;
        end else begin
          done_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
        addr_nxt  = '0;
        ready_nxt = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  assign entry_ready_o      = ready;
  assign remap_colSel_vec_o = colsel;
  assign remap_c2v_vec_o    = c2v;
  assign remap_dataIn_vec_o = data;
  assign nRemap_en_o        = nremap;
  assign busy_o             = busy;
  assign done_o             = done;
  assign aborted_o          = aborted;

endmodule
`default_nettype wire

// File: doc/memshare_ib_remap_loader.md
Name: memshare_ib_remap_loader

Overview:
- Upstream sequencer for the share-group IB-RAM rank.
- Streams a new IB-LUT image, one rank-wide word per address, from the LUT-generation stage into the rank's remap port.
- Walks every rank address ({col_sel, c2v}), drives the active-low remap enable, and reports completion.
- The decoder holds the rank in map mode until done_o fires.

Parameters:
- MSG_WIDTH, 4, message quantisation width (QUAN_SIZE).
- GROUP_SIZE, 4, VNs per share group (SHARE_GROUP_SIZE).
- COL_SEL_WIDTH, 1, column-select bits per VN (GP2 width; GP1 members ignore the MSB).
- ADDR_WIDTH, COL_SEL_WIDTH+MSG_WIDTH, rank address width per VN.
- ENTRY_NUM, 2**ADDR_WIDTH, words per full LUT image.

Ports:
- sys_clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- load_req_i  in  1  one-cycle pulse that starts an image load
- load_abort_i  in  1  abandons the current load
- entry_valid_i  in  1  upstream word valid
- entry_data_i  in  MSG_WIDTH*GROUP_SIZE  one LUT word; VN g occupies bits [(g+1)*MSG_WIDTH-1 : g*MSG_WIDTH]
- entry_ready_o  out  1  loader accepts entry_data_i this cycle
- remap_colSel_vec_o  out  COL_SEL_WIDTH*GROUP_SIZE  address high field, replicated per VN
- remap_c2v_vec_o  out  MSG_WIDTH*GROUP_SIZE  address low field, replicated per VN
- remap_dataIn_vec_o  out  MSG_WIDTH*GROUP_SIZE  write data to the rank
- nRemap_en_o  out  1  active-low rank write enable
- busy_o  out  1  load in progress
- done_o  out  1  one-cycle pulse after the last word is written
- aborted_o  out  1  one-cycle pulse when an abort is taken

Behaviour:
- Reset, asynchronous on rstn low. All outputs are registered and take these values:
  - state = IDLE, address counter = 0
  - nRemap_en_o = 1, entry_ready_o = 0, busy_o = 0, done_o = 0, aborted_o = 0
  - address and data vectors = 0
- Reset while in LOAD discards the partial image. No done_o is produced.
- FSM states: IDLE, LOAD, FINISH.
- IDLE:
  - load_req_i = 1 moves to LOAD next cycle, with addr_cnt = 0, busy_o = 1, entry_ready_o = 1.
  - load_abort_i is ignored in IDLE.
- LOAD:
  - entry_ready_o = 1 throughout.
  - Accept = entry_valid_i & entry_ready_o. In an accept cycle t, at t+1 the outputs are:
    - nRemap_en_o = 0
    - remap_colSel_vec_o = GROUP_SIZE copies of addr_cnt[ADDR_WIDTH-1:MSG_WIDTH]
    - remap_c2v_vec_o = GROUP_SIZE copies of addr_cnt[MSG_WIDTH-1:0]
    - remap_dataIn_vec_o = entry_data_i captured at t
    - addr_cnt increments by 1
  - In a non-accept cycle (bubble), nRemap_en_o = 1 the next cycle. Address and data hold their last values.
  - Write latency is exactly 1 cycle from accept.
  - Accepting the word at addr_cnt = ENTRY_NUM-1:
    - moves to FINISH
    - entry_ready_o = 0 next cycle
    - addr_cnt wraps to 0
- FINISH (1 cycle):
  - nRemap_en_o = 0 for the final write.
  - done_o pulses in the following cycle, together with busy_o falling and nRemap_en_o returning to 1.
  - Then IDLE.
- Abort, when load_abort_i = 1 in LOAD or FINISH:
  - Abort wins over a simultaneous accept; that word is not written.
  - Next cycle: IDLE, nRemap_en_o = 1, entry_ready_o = 0, busy_o = 0, aborted_o = 1, addr_cnt = 0.
  - No done_o is produced.
- load_req_i while busy_o = 1 is ignored; no restart.
- load_req_i in the same cycle that done_o pulses is legal and starts a new load.
- Exactly ENTRY_NUM writes occur per completed load, in ascending address order, with no duplicates.
- Each address is written at most once even under arbitrary bubbles.

Test Plan:
- Back-to-back load:
  - Stimulus: defaults; load_req_i, then 32 words with entry_valid_i held high, word k = {4{k[3:0]}}.
  - Response: nRemap_en_o low for exactly 32 consecutive cycles; colSel = 0 for addr 0-15 and 1 for addr 16-31; remap_dataIn_vec_o equals word k one cycle after its accept; done_o pulses once.
- Bubbled stream:
  - Stimulus: entry_valid_i toggles 1,0,0,1 in a repeating pattern.
  - Response: nRemap_en_o high in every bubble follow-up cycle; still exactly 32 writes at addresses 0..31; done_o only after the 32nd write.
- Abort mid-load:
  - Stimulus: assert load_abort_i at the cycle accepting address 10.
  - Response: address 10 is not written; next cycle aborted_o = 1, busy_o = 0, nRemap_en_o = 1; a subsequent load restarts at address 0.
- Reset mid-load:
  - Stimulus: drop rstn asynchronously after 5 writes.
  - Response: all outputs are at reset values immediately; no done_o; a clean 32-word load follows.
- Spurious requests:
  - Stimulus: load_req_i pulsed during LOAD; load_abort_i pulsed in IDLE.
  - Response: the load is not restarted (address sequence continuous); IDLE is unaffected; aborted_o stays 0.
- Chained load:
  - Stimulus: load_req_i in the done_o cycle.
  - Response: second load begins with addr 0; total 64 writes; two done_o pulses.
